// File: rtl/ara_pe_req_broadcast_pkg.sv
// Shared types for the PE request broadcaster: request payload, functional-unit
// enum, PE index offsets and the helper that turns a unit into a PE target mask.
package ara_pe_req_broadcast_pkg;

  localparam int unsigned NrVInsn = 8;
  localparam int unsigned MaxNrPEs = 32;

  // Non-lane PEs sit right above the lanes in the PE vector.
  localparam int unsigned OffsetLoad  = 0;
  localparam int unsigned OffsetStore = 1;
  localparam int unsigned OffsetSlide = 2;
  localparam int unsigned OffsetMask  = 3;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [NrVInsn-1:0]         vinsn_mask_t;

  typedef enum logic [2:0] {
    VFU_Alu,
    VFU_MFpu,
    VFU_LoadUnit,
    VFU_StoreUnit,
    VFU_SlideUnit,
    VFU_MaskUnit,
    VFU_None
  } vfu_e;

  typedef enum logic {
    IDLE,
    BCAST
  } bcast_state_e;

  typedef struct packed {
    vid_t        id;
    logic [5:0]  op;
    vfu_e        vfu;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic        use_vs1;
    logic        vm;
    logic [15:0] vl;
    vinsn_mask_t vinsn_running;
    vinsn_mask_t hazard_vs1;
    vinsn_mask_t hazard_vs2;
    vinsn_mask_t hazard_vd;
    vinsn_mask_t hazard_vm;
  } pe_req_t;

  // Lanes or the owning unit; a masked op (vm=0) also needs the mask unit.
  function automatic logic [MaxNrPEs-1:0] vfu_target(input vfu_e vfu, input logic vm,
                                                      input int unsigned nr_lanes);
    logic [MaxNrPEs-1:0] t;
    t = '0;
    unique case (vfu)
      VFU_Alu, VFU_MFpu: t = (MaxNrPEs'(1) << nr_lanes) - MaxNrPEs'(1);
      VFU_LoadUnit:      t = MaxNrPEs'(1) << (nr_lanes + OffsetLoad);
      VFU_StoreUnit:     t = MaxNrPEs'(1) << (nr_lanes + OffsetStore);
      VFU_SlideUnit:     t = MaxNrPEs'(1) << (nr_lanes + OffsetSlide);
      VFU_MaskUnit:      t = MaxNrPEs'(1) << (nr_lanes + OffsetMask);
      default:           t = '0;
    endcase
    if (!vm && vfu != VFU_None) t = t | (MaxNrPEs'(1) << (nr_lanes + OffsetMask));
    return t;
  endfunction

endpackage

// File: rtl/ara_pe_req_broadcast.sv
// Holds one issued request and hands it to each targeted PE independently,
// pruning hazard bits against the live running vector and counting stall cycles.
module ara_pe_req_broadcast
  import ara_pe_req_broadcast_pkg::*;
#(
  parameter int unsigned NrLanes        = 4,
  parameter int unsigned NrPEs          = NrLanes + 4,
  parameter int unsigned StallCntWidth  = 16,
  parameter int unsigned StallThreshold = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  pe_req_t                  req_i,
  input  logic [NrPEs-1:0]         req_target_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [NrVInsn-1:0]       vinsn_running_i,
  output pe_req_t                  pe_req_o,
  output logic [NrPEs-1:0]         pe_req_valid_o,
  input  logic [NrPEs-1:0]         pe_req_ready_i,
  output logic                     busy_o,
  output logic [StallCntWidth-1:0] stall_cnt_o,
  output logic                     stall_o
);

  localparam logic [StallCntWidth-1:0] StallThr = StallCntWidth'(StallThreshold);

  bcast_state_e             state_q, state_d;
  logic [NrPEs-1:0]         pending_q, pending_d, pending_left;
  pe_req_t                  req_q, req_d;
  logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic                     capture;

  function automatic logic [StallCntWidth-1:0] sat_inc(input logic [StallCntWidth-1:0] c);
    return (c == '1) ? c : c + StallCntWidth'(1);
  endfunction

  // Hazards may only clear while held: a newly running insn is younger, not a dependency.
  function automatic pe_req_t prune(input pe_req_t r, input vinsn_mask_t run);
    pe_req_t p;
    p               = r;
    p.vinsn_running = run;
    p.hazard_vs1    = r.hazard_vs1 & run;
    p.hazard_vs2    = r.hazard_vs2 & run;
    p.hazard_vd     = r.hazard_vd & run;
    p.hazard_vm     = r.hazard_vm & run;
    return p;
  endfunction

  assign pending_left = pending_q & ~pe_req_ready_i;
  assign req_ready_o  = (state_q == IDLE) | (pending_left == '0);
  assign capture      = req_valid_i & req_ready_o & (|req_target_i);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    req_d       = req_q;
    stall_cnt_d = stall_cnt_q;
    if (capture) begin
      state_d     = BCAST;
      pending_d   = req_target_i;
      req_d       = prune(req_i, vinsn_running_i);
      stall_cnt_d = '0;
    end else if (state_q == BCAST) begin
      pending_d = pending_left;
      req_d     = prune(req_q, vinsn_running_i);
      if (pending_left == '0) state_d = IDLE;
      else                    stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      req_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_q       <= req_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pe_req_o       = req_q;
  assign pe_req_valid_o = pending_q;
  assign busy_o         = (state_q == BCAST);
  assign stall_cnt_o    = stall_cnt_q;
  assign stall_o        = (stall_cnt_q >= StallThr);

  a_pending_iff_bcast: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((pending_q == '0) == (state_q == IDLE)));

endmodule

// File: tb/tb_ara_pe_req_broadcast.sv
// Directed bench for the PE request broadcaster with StallThreshold=4.
module tb_ara_pe_req_broadcast;
  import ara_pe_req_broadcast_pkg::*;

  localparam int unsigned NrLanes = 4;
  localparam int unsigned NrPEs   = NrLanes + 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  pe_req_t       req;
  logic [7:0]    target;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    running;
  pe_req_t       pe_req;
  logic [7:0]    pe_valid;
  logic [7:0]    pe_ready;
  logic          busy;
  logic [15:0]   stall_cnt;
  logic          stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ara_pe_req_broadcast #(
    .NrLanes(NrLanes),
    .StallCntWidth(16),
    .StallThreshold(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req),
    .req_target_i   (target),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .vinsn_running_i(running),
    .pe_req_o       (pe_req),
    .pe_req_valid_o (pe_valid),
    .pe_req_ready_i (pe_ready),
    .busy_o         (busy),
    .stall_cnt_o    (stall_cnt),
    .stall_o        (stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pe_req_t mk_req(input int id, input vfu_e vfu, input logic [7:0] hz);
    pe_req_t r;
    r            = '0;
    r.id         = vid_t'(id);
    r.vfu        = vfu;
    r.vd         = 5'(id + 1);
    r.vl         = 16'(100 + id);
    r.hazard_vs1 = hz;
    r.hazard_vs2 = hz;
    return r;
  endfunction

  initial begin
    rst_ni    = 1'b0;
    req       = '0;
    target    = '0;
    req_valid = 1'b0;
    running   = '0;
    pe_ready  = '0;
    #12;
    check_eq("rst_valid", pe_valid, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_cnt", stall_cnt, 16'd0);
    check_eq("rst_req", pe_req, '0);
    check_eq("rst_ready", req_ready, 1'b1);
    rst_ni = 1'b1;
    step();

    check_eq("tgt_alu", vfu_target(VFU_Alu, 1'b1, NrLanes), 32'h0F);
    check_eq("tgt_alu_vm0", vfu_target(VFU_Alu, 1'b0, NrLanes), 32'h8F);
    check_eq("tgt_store", vfu_target(VFU_StoreUnit, 1'b1, NrLanes), 32'h20);
    check_eq("tgt_load_vm0", vfu_target(VFU_LoadUnit, 1'b0, NrLanes), 32'h90);

    // All-ready: four back-to-back issues, one cycle each.
    pe_ready = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      req = mk_req(k, VFU_Alu, 8'h00); target = 8'h0F; req_valid = 1'b1;
      #1;
      check_eq($sformatf("b2b_ready%0d", k), req_ready, 1'b1);
      if (k > 0) begin
        check_eq($sformatf("b2b_valid%0d", k), pe_valid, 8'h0F);
        check_eq($sformatf("b2b_id%0d", k), pe_req.id, vid_t'(k - 1));
        check_eq($sformatf("b2b_cnt%0d", k), stall_cnt, 16'd0);
      end
      step();
    end
    req_valid = 1'b0;
    #1;
    check_eq("b2b_last_valid", pe_valid, 8'h0F);
    check_eq("b2b_last_vl", pe_req.vl, 16'd103);
    step();
    check_eq("b2b_idle_valid", pe_valid, 8'h00);
    check_eq("b2b_idle_busy", busy, 1'b0);

    // Staggered accept: lane 2 holds off for two cycles.
    req = mk_req(5, VFU_Alu, 8'h00); target = 8'h1F; req_valid = 1'b1; pe_ready = 8'hFB;
    step();
    req = mk_req(6, VFU_StoreUnit, 8'h00); target = 8'h20;
    #1;
    check_eq("stg_valid0", pe_valid, 8'h1F);
    check_eq("stg_ready0", req_ready, 1'b0);
    step();
    check_eq("stg_valid1", pe_valid, 8'h04);
    check_eq("stg_ready1", req_ready, 1'b0);
    check_eq("stg_cnt1", stall_cnt, 16'd1);
    check_eq("stg_id1", pe_req.id, vid_t'(5));
    step();
    pe_ready = 8'hFF;
    #1;
    check_eq("stg_valid2", pe_valid, 8'h04);
    check_eq("stg_cnt2", stall_cnt, 16'd2);
    check_eq("stg_ready2", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    #1;
    check_eq("stg_new_valid", pe_valid, 8'h20);
    check_eq("stg_new_id", pe_req.id, vid_t'(6));
    check_eq("stg_new_cnt", stall_cnt, 16'd0);
    check_eq("stg_new_busy", busy, 1'b1);
    step();
    check_eq("stg_done_busy", busy, 1'b0);

    // Hazard pruning at capture and while held.
    req = mk_req(2, VFU_Alu, 8'hFF); req.hazard_vs1 = 8'b0000_0110;
    target = 8'h01; req_valid = 1'b1; pe_ready = 8'h00; running = 8'b0000_0110;
    step();
    req_valid = 1'b0;
    #1;
    check_eq("hz_vs1_cap", pe_req.hazard_vs1, 8'h06);
    check_eq("hz_vs2_cap", pe_req.hazard_vs2, 8'h06);
    check_eq("hz_run_cap", pe_req.vinsn_running, 8'h06);
    running = 8'b0000_1100;
    step();
    check_eq("hz_vs1_prune", pe_req.hazard_vs1, 8'h04);
    check_eq("hz_vs2_prune", pe_req.hazard_vs2, 8'h04);
    check_eq("hz_run_upd", pe_req.vinsn_running, 8'h0C);
    check_eq("hz_vl_stable", pe_req.vl, 16'd102);
    pe_ready = 8'hFF; running = 8'h00;
    step();
    check_eq("hz_done_busy", busy, 1'b0);

    // Zero target is acknowledged and dropped.
    req = mk_req(7, VFU_Alu, 8'h00); target = 8'h00; req_valid = 1'b1;
    #1;
    check_eq("zt_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check_eq("zt_valid", pe_valid, 8'h00);
    check_eq("zt_busy", busy, 1'b0);

    // Watchdog on a store PE that never accepts.
    req = mk_req(3, VFU_StoreUnit, 8'h00); target = 8'h20; req_valid = 1'b1; pe_ready = 8'hDF;
    step();
    req_valid = 1'b0;
    check_eq("wd_cnt0", stall_cnt, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("wd_cnt%0d", i), stall_cnt, 16'(i));
      check_eq($sformatf("wd_stall%0d", i), stall, (i >= 4) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 65540; i++) step();
    check_eq("wd_sat", stall_cnt, 16'hFFFF);
    check_eq("wd_sat_stall", stall, 1'b1);
    check_eq("wd_busy", busy, 1'b1);
    check_eq("wd_vl_stable", pe_req.vl, 16'd103);
    pe_ready = 8'hFF;
    #1;
    check_eq("wd_release_ready", req_ready, 1'b1);
    step();
    check_eq("wd_release_busy", busy, 1'b0);
    check_eq("wd_release_cnt", stall_cnt, 16'hFFFF);
    check_eq("wd_release_valid", pe_valid, 8'h00);

    // Asynchronous reset mid-broadcast.
    req = mk_req(1, VFU_LoadUnit, 8'h00); target = 8'h10; req_valid = 1'b1; pe_ready = 8'h00;
    step();
    req_valid = 1'b0;
    check_eq("ar_valid_before", pe_valid, 8'h10);
    check_eq("ar_cnt_cleared", stall_cnt, 16'd0);
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("ar_valid_drop", pe_valid, 8'h00);
    check_eq("ar_busy_drop", busy, 1'b0);
    check_eq("ar_req_clear", pe_req, '0);
    rst_ni = 1'b1;
    #1;
    check_eq("ar_ready_after", req_ready, 1'b1);
    step();
    check_eq("ar_idle_busy", busy, 1'b0);
    check_eq("ar_idle_valid", pe_valid, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
